// File: rtl/sw_ref_arb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sw_ref_arb_pkg : shared widths and FSM encoding for the arbiter  |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
package sw_ref_arb_pkg;

    localparam int ADDR_W = 25;
    localparam int LEN_W  = 25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        STREAM = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | rr_pick : first set request at or after ptr, wrapping            |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
module rr_pick #(
    parameter int NUM_ENGINES = 4
) (
    input  logic [NUM_ENGINES-1:0]         req,
    input  logic [$clog2(NUM_ENGINES)-1:0] ptr,
    output logic [$clog2(NUM_ENGINES)-1:0] idx,
    output logic                           found
);

    localparam int IDX_W = $clog2(NUM_ENGINES);

    int cand;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < NUM_ENGINES; off++) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_ENGINES) begin
                cand = cand - NUM_ENGINES;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ref_reader_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | ref_reader_arbiter : round-robin share of one DRAM ref reader    |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
module ref_reader_arbiter
    import sw_ref_arb_pkg::*;
#(
    parameter int NUM_ENGINES = 4,
    parameter int REF_LENGTH  = 128
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [25*NUM_ENGINES-1:0]       eng_ref_addr_in,
    input  logic [25*NUM_ENGINES-1:0]       eng_ref_length_in,
    input  logic [NUM_ENGINES-1:0]          eng_ref_info_valid_in,
    output logic [2*REF_LENGTH-1:0]         eng_ref_seq_block_out,
    output logic [NUM_ENGINES-1:0]          eng_ref_seq_block_valid_out,
    input  logic [NUM_ENGINES-1:0]          eng_ref_seq_block_rdy_in,
    output logic [ADDR_W-1:0]               rd_ref_addr_out,
    output logic [LEN_W-1:0]                rd_ref_length_out,
    output logic                            rd_ref_info_valid_out,
    input  logic                            rd_ref_info_rdy_in,
    input  logic [2*REF_LENGTH-1:0]         rd_ref_seq_block_in,
    input  logic                            rd_ref_seq_block_valid_in,
    output logic                            rd_ref_seq_block_rdy_out,
    output logic [$clog2(NUM_ENGINES)-1:0]  grant_id_out,
    output logic                            busy_out,
    output logic                            req_overflow_err_out
);

    localparam int IDX_W = $clog2(NUM_ENGINES);

    arb_state_t              state;
    logic [IDX_W-1:0]        grant;
    logic [IDX_W-1:0]        rr_ptr;
    logic [NUM_ENGINES-1:0]  pending;
    logic [ADDR_W-1:0]       addr_q [NUM_ENGINES];
    logic [LEN_W-1:0]        len_q  [NUM_ENGINES];
    logic [LEN_W-1:0]        blk_cnt;
    logic                    issue_valid;
    logic [ADDR_W-1:0]       issue_addr;
    logic [LEN_W-1:0]        issue_len;
    logic                    busy;
    logic                    overflow_err;

    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_found;
    logic                    blk_hs;
    logic                    complete;
    logic [IDX_W-1:0]        next_ptr;

    rr_pick #(
        .NUM_ENGINES (NUM_ENGINES)
    ) u_rr_pick (
        .req   (pending),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Block path is a pure pass-through; only valid/ready are steered by grant.
    always_comb begin
        eng_ref_seq_block_valid_out = '0;
        rd_ref_seq_block_rdy_out    = 1'b0;
        if (state == STREAM) begin
            eng_ref_seq_block_valid_out[grant] = rd_ref_seq_block_valid_in;
            rd_ref_seq_block_rdy_out           = eng_ref_seq_block_rdy_in[grant];
        end
        blk_hs   = (state == STREAM) && rd_ref_seq_block_valid_in
                   && eng_ref_seq_block_rdy_in[grant];
        complete = ((state == ISSUE) && rd_ref_info_rdy_in && (issue_len == '0))
                   || (blk_hs && (blk_cnt == LEN_W'(1)));
        next_ptr = (grant == IDX_W'(NUM_ENGINES - 1)) ? '0 : grant + IDX_W'(1);
    end

    assign eng_ref_seq_block_out = rd_ref_seq_block_in;
    assign rd_ref_addr_out       = issue_addr;
    assign rd_ref_length_out     = issue_len;
    assign rd_ref_info_valid_out = issue_valid;
    assign grant_id_out          = grant;
    assign busy_out              = busy;
    assign req_overflow_err_out  = overflow_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= '0;
            rr_ptr       <= '0;
            pending      <= '0;
            blk_cnt      <= '0;
            issue_valid  <= 1'b0;
            issue_addr   <= '0;
            issue_len    <= '0;
            busy         <= 1'b0;
            overflow_err <= 1'b0;
            for (int i = 0; i < NUM_ENGINES; i++) begin
                addr_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else begin
            if (complete) begin
                pending[grant] <= 1'b0;
            end
            // A request landing on the slot being retired this cycle is kept.
            for (int i = 0; i < NUM_ENGINES; i++) begin
                if (eng_ref_info_valid_in[i]) begin
                    if (!pending[i] || (complete && (grant == IDX_W'(i)))) begin
                        pending[i] <= 1'b1;
                        addr_q[i]  <= eng_ref_addr_in[i*25 +: 25];
                        len_q[i]   <= eng_ref_length_in[i*25 +: 25];
                    end else begin
                        overflow_err <= 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant       <= pick_idx;
                        blk_cnt     <= len_q[pick_idx];
                        issue_valid <= 1'b1;
                        issue_addr  <= addr_q[pick_idx];
                        issue_len   <= len_q[pick_idx];
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (rd_ref_info_rdy_in) begin
                        issue_valid <= 1'b0;
                        if (issue_len == '0) begin
                            rr_ptr <= next_ptr;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (blk_hs && (blk_cnt != '0)) begin
                        blk_cnt <= blk_cnt - LEN_W'(1);
                        if (blk_cnt == LEN_W'(1)) begin
                            rr_ptr <= next_ptr;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ref_reader_arbiter.md
# ref_reader_arbiter

Shares one DRAM reference reader among `NUM_ENGINES` Smith-Waterman engine units.
- Latches each engine's reference request (address, block count).
- Grants the reader to one engine at a time in round-robin order.
- Issues the request to the reader and routes the returned reference blocks to the granted engine until its full block count is delivered.
- Sits between the engines' DRAM reference reader interfaces and the single DRAM reader.

## Interface
Parameters:
- `NUM_ENGINES`, 4, number of engine units sharing the reader (2..16)
- `REF_LENGTH`, 128, characters per reference block; block bus is `2*REF_LENGTH` bits

Ports:
- `clk`  in  1  system clock; one clock domain, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `eng_ref_addr_in`  in  `25*NUM_ENGINES`  per-engine DRAM start address; slice i belongs to engine i
- `eng_ref_length_in`  in  `25*NUM_ENGINES`  per-engine block count
- `eng_ref_info_valid_in`  in  `NUM_ENGINES`  one-cycle request pulse per engine; no ready
- `eng_ref_seq_block_out`  out  `2*REF_LENGTH`  block bus, broadcast to all engines
- `eng_ref_seq_block_valid_out`  out  `NUM_ENGINES`  block valid, one-hot to the granted engine
- `eng_ref_seq_block_rdy_in`  in  `NUM_ENGINES`  per-engine block ready
- `rd_ref_addr_out`  out  25  request address to the reader
- `rd_ref_length_out`  out  25  request block count to the reader
- `rd_ref_info_valid_out`  out  1  request valid to the reader
- `rd_ref_info_rdy_in`  in  1  reader accepts the request
- `rd_ref_seq_block_in`  in  `2*REF_LENGTH`  block from the reader
- `rd_ref_seq_block_valid_in`  in  1  reader block valid
- `rd_ref_seq_block_rdy_out`  out  1  block accepted
- `grant_id_out`  out  `$clog2(NUM_ENGINES)`  currently granted engine
- `busy_out`  out  1  state is not IDLE
- `req_overflow_err_out`  out  1  sticky; set when a request arrives while that engine already has one pending

## Operation
- **Request slots (per engine i):** `pending[i]`, `addr[i]`, `len[i]`.
  - On `eng_ref_info_valid_in[i]` with `pending[i]=0`: capture addr/len and set `pending[i]`.
  - On valid with `pending[i]=1` and the slot not being cleared this cycle: request ignored, set `req_overflow_err_out`.
  - Clear and new request in the same cycle: the new request is captured (set wins).
- **FSM: IDLE -> ISSUE -> STREAM -> IDLE.**
- **IDLE:** if any `pending`, pick the first pending index at or after `rr_ptr` (wrapping). Register `grant`, load `blk_cnt = len[grant]`, go to ISSUE.
- **ISSUE:** `rd_ref_info_valid_out=1` with `addr[grant]` and `len[grant]`. Hold until `rd_ref_info_rdy_in`.
  - On accept with `len != 0`: go to STREAM.
  - On accept with `len == 0`: complete immediately.
- **STREAM:** combinational pass-through, no buffering.
  - `eng_ref_seq_block_valid_out[grant] = rd_ref_seq_block_valid_in`; all other bits 0.
  - `rd_ref_seq_block_rdy_out = eng_ref_seq_block_rdy_in[grant]`.
  - `eng_ref_seq_block_out = rd_ref_seq_block_in` at all times.
  - Each handshake decrements `blk_cnt`. A handshake at `blk_cnt==1` completes the stream.
- **Completion:** clear `pending[grant]`, set `rr_ptr = grant+1` (mod `NUM_ENGINES`), go to IDLE.
- **Outside STREAM:** `rd_ref_seq_block_rdy_out=0` and all block valids 0.
- **Arithmetic:** `blk_cnt` is 25 bits unsigned and never underflows.

## Timing
- **Reset values:** state IDLE, `rr_ptr=0`, `grant=0`, `pending=0`, `blk_cnt=0`. All valid/rdy outputs 0, `grant_id_out=0`, `busy_out=0`, `req_overflow_err_out=0`; address/length outputs 0.
- **Reset mid-stream:** returns to IDLE next cycle; all pending requests are discarded.
- **Request latency:** request pulse at cycle N -> `pending` at N+1 -> ISSUE (`rd_ref_info_valid_out=1`) at N+2 if the reader is free.
- **Block latency:** 0 cycles, pure combinational path reader -> engine.
- **Request-to-request gap:** completion at cycle M -> IDLE at M+1 -> next ISSUE at M+2. Minimum 1 idle cycle between grants.
- **Output timing:** `grant_id_out` and `busy_out` are registered and change on the state transition edge.

## Structure
- Package `sw_ref_arb_pkg`:
  - `ADDR_W=25`, `LEN_W=25`
  - FSM state enum `{IDLE, ISSUE, STREAM}`
- Sub-module `rr_pick`: combinational round-robin picker. Inputs `NUM_ENGINES`-bit request vector and pointer; outputs index and found flag.

## Test plan
- **Single request:** engine 2 requests addr 0x100, len 3; reader accepts 1 cycle later; 3 blocks with rdy held high -> one rd request with addr 0x100/len 3; `eng_ref_seq_block_valid_out = 4'b0100` for exactly 3 handshakes; IDLE after; `rr_ptr=3`.
- **Round-robin order:** all 4 engines pulse in the same cycle, each len 1 -> grants 0,1,2,3. Then engines 0 and 3 re-request with `rr_ptr=0` after wrap -> grant 0 then 3.
- **Backpressure:** granted engine drops rdy for 5 cycles mid-stream -> `rd_ref_seq_block_rdy_out=0` for those cycles, `blk_cnt` frozen, no block lost or duplicated.
- **Zero length:** len 0 -> single rd request issued; no STREAM; `pending` cleared after rdy.
- **Overflow and reset:** engine 1 pulses twice while pending -> `req_overflow_err_out=1`, sticky. `rst` asserted mid-STREAM -> all outputs at reset values next cycle.
